// File: rtl/dsp_sync_pkg.sv
// Shared constants for the dsp_sync multiply-accumulate slice: operand widths,
// OPMODE bit positions, X/Z mux encodings and a parameter sanity helper.
package dsp_sync_pkg;

    localparam int AB_W     = 18;
    localparam int M_W      = 36;
    localparam int P_W      = 48;
    localparam int OPMODE_W = 8;

    localparam int POST_SUB   = 7;
    localparam int PREADD_SUB = 6;
    localparam int CIN_OP     = 5;
    localparam int PREADD_SEL = 4;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

    function automatic bit reg_param_ok(input int v);
        return (v == 0) || (v == 1);
    endfunction

    // 49-bit post-adder; bit 48 is carry on add and borrow on subtract.
    function automatic logic [P_W:0] post_add(
        input logic [P_W-1:0] z,
        input logic [P_W-1:0] x,
        input logic           cin,
        input logic           sub
    );
        logic [P_W:0] xc;
        xc = {1'b0, x} + {{P_W{1'b0}}, cin};
        if (sub)
            return {1'b0, z} - xc;
        else
            return {1'b0, z} + xc;
    endfunction

endpackage

// File: rtl/dsp_sync_reg.sv
// One optional pipeline stage: registered with CE and async clear when REG is
// nonzero, otherwise a plain wire from input to output.
module dsp_sync_reg
    import dsp_sync_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst)
                    r_q <= '0;
                else if (i_ce)
                    r_q <= i_d;
            end

            assign o_q = r_q;
        end else begin : g_bypass
            // Clock, clear and enable are meaningless for a bypassed stage.
            logic w_unused_ctrl;
            assign w_unused_ctrl = i_clk ^ i_rst ^ i_ce;
            assign o_q = i_d;
        end
    endgenerate

endmodule

// File: rtl/dsp_sync.sv
// dsp_sync: pipelined 18x18 pre-add/multiply/post-add slice with per-stage bypass.
// Define DSP_SYNC_PARAM_CHECK_EN to reject illegal parameter values at elaboration.
module dsp_sync
    import dsp_sync_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "ASYNC"
) (
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic        CLK,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    input  logic [17:0] BCIN,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [47:0] PCIN,
    output logic [17:0] BCOUT,
    output logic [47:0] PCOUT,
    output logic [47:0] P,
    output logic [35:0] M,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

`ifdef DSP_SYNC_PARAM_CHECK_EN
    generate
        if (B_INPUT != "DIRECT" && B_INPUT != "CASCADE") begin : g_bad_b_input
            $error("dsp_sync: B_INPUT must be DIRECT or CASCADE");
        end
        if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_cinsel
            $error("dsp_sync: CARRYINSEL must be OPMODE5 or CARRYIN");
        end
        if (!(reg_param_ok(A0REG) && reg_param_ok(A1REG) && reg_param_ok(B0REG) &&
              reg_param_ok(B1REG) && reg_param_ok(CREG) && reg_param_ok(DREG) &&
              reg_param_ok(MREG) && reg_param_ok(PREG) && reg_param_ok(CARRYINREG) &&
              reg_param_ok(CARRYOUTREG) && reg_param_ok(OPMODEREG))) begin : g_bad_reg
            $error("dsp_sync: every *REG parameter must be 0 or 1");
        end
    endgenerate
`endif

    localparam bit B_CASCADE  = (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_OP = (CARRYINSEL == "OPMODE5");
    localparam bit CIN_FROM_PIN = (CARRYINSEL == "CARRYIN");

    // All clears are asynchronous regardless of RSTTYPE.
    logic w_unused_rsttype;
    assign w_unused_rsttype = (RSTTYPE == "SYNC");

    logic [AB_W-1:0]     w_b_src;
    logic [AB_W-1:0]     w_b0;
    logic [AB_W-1:0]     w_d;
    logic [OPMODE_W-1:0] w_op;
    logic [AB_W-1:0]     w_preadd;
    logic [AB_W-1:0]     w_b1_in;
    logic [AB_W-1:0]     w_b1;
    logic [AB_W-1:0]     w_a0;
    logic [AB_W-1:0]     w_a1;
    logic [M_W-1:0]      w_mult;
    logic [M_W-1:0]      w_m;
    logic [P_W-1:0]      w_c;
    logic                w_cin_src;
    logic                w_cin;
    logic [P_W-1:0]      w_x;
    logic [P_W-1:0]      w_z;
    logic [P_W:0]        w_sum;
    logic [P_W-1:0]      w_p;
    logic                w_co;

    assign w_b_src = B_CASCADE ? BCIN : B;

    // ---------------- input stages ----------------
    dsp_sync_reg #(.WIDTH(AB_W), .REG(B0REG)) u_b0 (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CEB),
        .i_d   (w_b_src),
        .o_q   (w_b0)
    );

    dsp_sync_reg #(.WIDTH(AB_W), .REG(DREG)) u_d (
        .i_clk (CLK),
        .i_rst (RSTD),
        .i_ce  (CED),
        .i_d   (D),
        .o_q   (w_d)
    );

    dsp_sync_reg #(.WIDTH(OPMODE_W), .REG(OPMODEREG)) u_opmode (
        .i_clk (CLK),
        .i_rst (RSTOPMODE),
        .i_ce  (CEOPMODE),
        .i_d   (OPMODE),
        .o_q   (w_op)
    );

    dsp_sync_reg #(.WIDTH(AB_W), .REG(A0REG)) u_a0 (
        .i_clk (CLK),
        .i_rst (RSTA),
        .i_ce  (CEA),
        .i_d   (A),
        .o_q   (w_a0)
    );

    dsp_sync_reg #(.WIDTH(AB_W), .REG(A1REG)) u_a1 (
        .i_clk (CLK),
        .i_rst (RSTA),
        .i_ce  (CEA),
        .i_d   (w_a0),
        .o_q   (w_a1)
    );

    dsp_sync_reg #(.WIDTH(P_W), .REG(CREG)) u_c (
        .i_clk (CLK),
        .i_rst (RSTC),
        .i_ce  (CEC),
        .i_d   (C),
        .o_q   (w_c)
    );

    // ---------------- pre-adder and B1 ----------------
    assign w_preadd = w_op[PREADD_SUB] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in  = w_op[PREADD_SEL] ? w_preadd : w_b0;

    dsp_sync_reg #(.WIDTH(AB_W), .REG(B1REG)) u_b1 (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CEB),
        .i_d   (w_b1_in),
        .o_q   (w_b1)
    );

    assign BCOUT = w_b1;

    // ---------------- multiplier ----------------
    assign w_mult = M_W'(w_a1) * M_W'(w_b1);

    dsp_sync_reg #(.WIDTH(M_W), .REG(MREG)) u_m (
        .i_clk (CLK),
        .i_rst (RSTM),
        .i_ce  (CEM),
        .i_d   (w_mult),
        .o_q   (w_m)
    );

    assign M = w_m;

    // ---------------- carry-in ----------------
    always_comb begin
        w_cin_src = 1'b0;
        if (CIN_FROM_OP)
            w_cin_src = w_op[CIN_OP];
        else if (CIN_FROM_PIN)
            w_cin_src = CARRYIN;
    end

    dsp_sync_reg #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
        .i_clk (CLK),
        .i_rst (RSTCARRYIN),
        .i_ce  (CECARRYIN),
        .i_d   (w_cin_src),
        .o_q   (w_cin)
    );

    // ---------------- X / Z operand muxes ----------------
    always_comb begin
        w_x = '0;
        case (xsel_e'(w_op[1:0]))
            X_ZERO: w_x = '0;
            X_M:    w_x = {{(P_W-M_W){1'b0}}, w_m};
            X_P:    w_x = w_p;
            X_DAB:  w_x = {w_d[11:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (zsel_e'(w_op[3:2]))
            Z_ZERO: w_z = '0;
            Z_PCIN: w_z = PCIN;
            Z_P:    w_z = w_p;
            Z_C:    w_z = w_c;
            default: w_z = '0;
        endcase
    end

    // ---------------- post-adder and output stages ----------------
    assign w_sum = post_add(w_z, w_x, w_cin, w_op[POST_SUB]);

    dsp_sync_reg #(.WIDTH(P_W), .REG(PREG)) u_p (
        .i_clk (CLK),
        .i_rst (RSTP),
        .i_ce  (CEP),
        .i_d   (w_sum[P_W-1:0]),
        .o_q   (w_p)
    );

    dsp_sync_reg #(.WIDTH(1), .REG(CARRYOUTREG)) u_cyo (
        .i_clk (CLK),
        .i_rst (RSTCARRYIN),
        .i_ce  (CECARRYIN),
        .i_d   (w_sum[P_W]),
        .o_q   (w_co)
    );

    assign P         = w_p;
    assign PCOUT     = w_p;
    assign CARRYOUT  = w_co;
    assign CARRYOUTF = w_co;

endmodule

// File: tb/tb_dsp_sync.sv
// Directed testbench for dsp_sync with default parameters; expected values are
// hand-computed constants checked with immediate assertions.
module tb_dsp_sync;

    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CLK;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic        RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE;
    logic [17:0] BCOUT;
    logic [47:0] PCOUT, P;
    logic [35:0] M;
    logic        CARRYOUT, CARRYOUTF;

    int total = 0;
    int bad   = 0;

    dsp_sync dut (
        .A(A), .B(B), .D(D), .C(C), .CLK(CLK), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .BCIN(BCIN), .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC),
        .RSTD(RSTD), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE), .CEA(CEA),
        .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED), .CECARRYIN(CECARRYIN),
        .CEOPMODE(CEOPMODE), .PCIN(PCIN), .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_all_rst(input logic v);
        {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE} = {8{v}};
    endtask

    task automatic set_all_ce(input logic v);
        {CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE} = {8{v}};
    endtask

    initial begin
        set_all_rst(1'b1);
        set_all_ce(1'b1);
        A       = 18'($urandom);
        B       = 18'($urandom);
        D       = 18'($urandom);
        BCIN    = 18'($urandom);
        C       = {16'($urandom), 32'($urandom)};
        PCIN    = {16'($urandom), 32'($urandom)};
        CARRYIN = 1'($urandom);
        OPMODE  = 8'($urandom);

        // Reset state at the first falling edge
        @(negedge CLK);
        check("rst_bcout", 48'(BCOUT), 48'h0);
        check("rst_m", 48'(M), 48'h0);
        check("rst_p", P, 48'h0);
        check("rst_pcout", PCOUT, 48'h0);
        check("rst_co", 48'(CARRYOUT), 48'h0);
        check("rst_cof", 48'(CARRYOUTF), 48'h0);
        $display("txn reset: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // C - A*(D-B): 350 - 20*15 = 50
        set_all_rst(1'b0);
        OPMODE = 8'b1101_1101;
        A = 18'd20; B = 18'd10; C = 48'd350; D = 18'd25;
        PCIN = 48'd0; BCIN = 18'd0; CARRYIN = 1'b0;
        edges(4);
        check("mac_bcout", 48'(BCOUT), 48'hF);
        check("mac_m", 48'(M), 48'h12C);
        check("mac_p", P, 48'h32);
        check("mac_pcout", PCOUT, 48'h32);
        check("mac_co", 48'(CARRYOUT), 48'h0);
        check("mac_cof", 48'(CARRYOUTF), 48'h0);
        $display("txn mac_sub: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // Pre-add only, X=Z=0: P clears
        OPMODE = 8'b0001_0000;
        edges(3);
        check("padd_bcout", 48'(BCOUT), 48'h23);
        check("padd_m", 48'(M), 48'h2BC);
        check("padd_p", P, 48'h0);
        check("padd_co", 48'(CARRYOUT), 48'h0);
        $display("txn preadd: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // P + P feedback from zero stays zero; B1 bypasses pre-adder
        OPMODE = 8'b0000_1010;
        edges(3);
        check("fb_bcout", 48'(BCOUT), 48'hA);
        check("fb_m", 48'(M), 48'hC8);
        check("fb_p", P, 48'h0);
        check("fb_co", 48'(CARRYOUT), 48'h0);
        $display("txn feedback: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // PCIN - ({D,A,B} + 1) borrows
        OPMODE = 8'b1010_0111;
        A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
        edges(3);
        check("cat_bcout", 48'(BCOUT), 48'h6);
        check("cat_m", 48'(M), 48'h1E);
        check("cat_p", P, 48'hFE6F_FFEC_0BB1);
        check("cat_pcout", PCOUT, 48'hFE6F_FFEC_0BB1);
        check("cat_co", 48'(CARRYOUT), 48'h1);
        check("cat_cof", 48'(CARRYOUTF), 48'h1);
        $display("txn concat_sub: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // P holds with CEP=0 while upstream stages keep moving
        CEP = 1'b0;
        A = 18'd1; B = 18'd1;
        edges(3);
        check("hold_p", P, 48'hFE6F_FFEC_0BB1);
        check("hold_m", 48'(M), 48'h1);
        check("hold_bcout", 48'(BCOUT), 48'h1);
        $display("txn cep_hold: BCOUT=%h M=%h P=%h CO=%b", BCOUT, M, P, CARRYOUT);

        // Asynchronous clears take effect between edges
        #2 RSTP = 1'b1;
        #1;
        check("arst_p", P, 48'h0);
        check("arst_pcout", PCOUT, 48'h0);
        check("arst_co_kept", 48'(CARRYOUT), 48'h1);
        RSTM = 1'b1;
        #1;
        check("arst_m", 48'(M), 48'h0);
        $display("txn async_rst: M=%h P=%h CO=%b", M, P, CARRYOUT);
        RSTP = 1'b0;
        RSTM = 1'b0;
        CEP  = 1'b1;
        edges(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
